// File: rtl/parity_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : parity_rr_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one even/odd classifier
//            between N_REQ requesters. A winning byte is pulsed into the
//            classifier for one cycle. The registered result is captured and
//            returned to the winner on a valid/ready response channel.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N_REQ       number of requesters (2..8)
//   IDW         requester index width
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   req_valid   per-requester request valid          [N_REQ]
//   req_data    per-requester byte, lane i = [8i+7:8i] [8*N_REQ]
//   req_ready   one-hot accept, IDLE only             [N_REQ]
//   cls_valid   classifier in_valid (one-cycle pulse)
//   cls_data    classifier data_in
//   cls_even    classifier even result (registered)
//   cls_odd     classifier odd result (registered)
//   resp_valid  response valid
//   resp_id     index of the requester being answered [IDW]
//   resp_even   1 = even byte, 0 = odd byte
//   resp_ready  response consumer ready
//   busy        high whenever not IDLE
//   cls_err     sticky malformed-classifier-result flag
//   even_cnt    saturating count of even responses    [16]
//   odd_cnt     saturating count of odd responses     [16]
// Configuration
//   PARITY_ARB_STATS_EN  when defined, builds the even/odd response counters;
//                        otherwise even_cnt/odd_cnt are tied to zero.
// ============================================================================
module parity_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               cls_valid,
  output logic [7:0]         cls_data,
  input  logic               cls_even,
  input  logic               cls_odd,
  output logic               resp_valid,
  output logic [IDW-1:0]     resp_id,
  output logic               resp_even,
  input  logic               resp_ready,
  output logic               busy,
  output logic               cls_err,
  output logic [15:0]        even_cnt,
  output logic [15:0]        odd_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id_q;
  logic [7:0]     data_q;
  logic           resp_even_q;

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW:0]   cand;
  logic [7:0]     win_byte;
  logic [IDW-1:0] next_ptr;

  // --------------------------------------------------------------------------
  // Rotating-priority search. Offsets are visited from the highest down so
  // that the smallest offset from rr_ptr is the last (and winning) write.
  // --------------------------------------------------------------------------
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N_REQ)) begin
        cand = cand - (IDW+1)'(N_REQ);
      end
      if (req_valid[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end

  // Byte lane of the winner, selected with constant slices only.
  always_comb begin
    win_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDW'(i)) begin
        win_byte = req_data[8*i +: 8];
      end
    end
  end

  // Accept is only offered from IDLE and never while reset is held, which
  // keeps exactly one request in flight.
  always_comb begin
    req_ready = '0;
    if (reset && (state == S_IDLE) && win_found) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  assign next_ptr = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + IDW'(1);

  // --------------------------------------------------------------------------
  // Sequencer: IDLE -> ISSUE -> WAIT -> RESP -> IDLE
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      id_q        <= '0;
      data_q      <= 8'h00;
      resp_even_q <= 1'b0;
      cls_valid   <= 1'b0;
      resp_valid  <= 1'b0;
      cls_err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            data_q    <= win_byte;
            id_q      <= win_idx;
            cls_valid <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cls_valid <= 1'b0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // The classifier result was registered on the ISSUE edge. A result
          // claiming both or neither class is untrustworthy: flag it and
          // answer from the byte's own LSB instead.
          if (cls_even == cls_odd) begin
            cls_err     <= 1'b1;
            resp_even_q <= ~data_q[0];
          end else begin
            resp_even_q <= cls_even;
          end
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            rr_ptr     <= next_ptr;
            state      <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign cls_data  = data_q;
  assign resp_id   = id_q;
  assign resp_even = resp_even_q;
  assign busy      = (state != S_IDLE);

  // --------------------------------------------------------------------------
  // Optional response statistics
  // --------------------------------------------------------------------------
`ifdef PARITY_ARB_STATS_EN
  logic        resp_done;
  logic [15:0] even_cnt_q;
  logic [15:0] odd_cnt_q;

  assign resp_done = (state == S_RESP) && resp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      even_cnt_q <= 16'h0000;
      odd_cnt_q  <= 16'h0000;
    end else if (resp_done) begin
      if (resp_even_q) begin
        if (even_cnt_q != 16'hFFFF) begin
          even_cnt_q <= even_cnt_q + 16'h0001;
        end
      end else begin
        if (odd_cnt_q != 16'hFFFF) begin
          odd_cnt_q <= odd_cnt_q + 16'h0001;
        end
      end
    end
  end

  assign even_cnt = even_cnt_q;
  assign odd_cnt  = odd_cnt_q;
`else
  assign even_cnt = 16'h0000;
  assign odd_cnt  = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_parity_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_rr_arbiter
// Purpose  : Self-checking bench for parity_rr_arbiter. Contains a behavioural
//            even/odd classifier and a transaction-level reference model of
//            rotating priority, response values and statistics.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parity_rr_arbiter;
  localparam int N_REQ = 4;
  localparam int IDW   = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [N_REQ-1:0]   req_valid = '0;
  logic [8*N_REQ-1:0] req_data = '0;
  logic [N_REQ-1:0]   req_ready;
  logic               cls_valid;
  logic [7:0]         cls_data;
  logic               cls_even;
  logic               cls_odd;
  logic               resp_valid;
  logic [IDW-1:0]     resp_id;
  logic               resp_even;
  logic               resp_ready = 1'b1;
  logic               busy;
  logic               cls_err;
  logic [15:0]        even_cnt;
  logic [15:0]        odd_cnt;

  parity_rr_arbiter #(.N_REQ(N_REQ)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .cls_valid(cls_valid), .cls_data(cls_data),
    .cls_even(cls_even), .cls_odd(cls_odd),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_even(resp_even),
    .resp_ready(resp_ready), .busy(busy), .cls_err(cls_err),
    .even_cnt(even_cnt), .odd_cnt(odd_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural classifier: registered even/odd value class of the byte.
  logic cls_even_r, cls_odd_r;
  logic force_bad = 1'b0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cls_even_r <= 1'b0;
      cls_odd_r  <= 1'b0;
    end else if (cls_valid) begin
      cls_even_r <= (cls_data % 2) == 0;
      cls_odd_r  <= (cls_data % 2) == 1;
    end
  end
  assign cls_even = force_bad ? 1'b1 : cls_even_r;
  assign cls_odd  = force_bad ? 1'b1 : cls_odd_r;

  // Reference model state
  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;
  int m_even = 0;
  int m_odd  = 0;
  bit m_err  = 0;
  int cls_pulses = 0;

  always @(negedge clk) if (cls_valid) cls_pulses++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_winner(input logic [N_REQ-1:0] pat, input int ptr);
    for (int k = 0; k < N_REQ; k++) begin
      if (pat[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    end
    return 0;
  endfunction

  function automatic logic [15:0] exp_cnt(input int n);
`ifdef PARITY_ARB_STATS_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return (n < 0) ? 16'h0001 : 16'h0000;
`endif
  endfunction

  // One full transaction with exact per-cycle expectations.
  task automatic run_txn(input logic [N_REQ-1:0] pat, input logic [8*N_REQ-1:0] data,
                         input int stall);
    int          w;
    logic [7:0]  b;
    logic        ev;
    @(negedge clk);
    req_valid  = pat;
    req_data   = data;
    resp_ready = (stall == 0);
    #1;
    w  = exp_winner(pat, m_ptr);
    b  = data[8*w +: 8];
    ev = (b % 2) == 0;
    check_eq("idle_req_ready", req_ready, 32'(1 << w));
    check_eq("idle_busy", busy, 0);
    @(posedge clk); #1;
    req_valid = 4'($urandom);
    req_data  = $urandom;
    check_eq("issue_cls_valid", cls_valid, 1);
    check_eq("issue_cls_data", cls_data, b);
    check_eq("issue_req_ready", req_ready, 0);
    check_eq("issue_busy", busy, 1);
    @(posedge clk); #1;
    check_eq("wait_cls_valid", cls_valid, 0);
    check_eq("wait_resp_valid", resp_valid, 0);
    check_eq("wait_req_ready", req_ready, 0);
    @(posedge clk); #1;
    if (force_bad) m_err = 1;
    check_eq("resp_valid", resp_valid, 1);
    check_eq("resp_id", resp_id, w);
    check_eq("resp_even", resp_even, ev);
    check_eq("resp_cls_err", cls_err, m_err);
    for (int s = 0; s < stall; s++) begin
      if (s == stall - 1) resp_ready = 1'b1;
      @(posedge clk); #1;
      if (s != stall - 1) begin
        req_valid = 4'($urandom);
        check_eq("stall_resp_valid", resp_valid, 1);
        check_eq("stall_resp_id", resp_id, w);
        check_eq("stall_resp_even", resp_even, ev);
        check_eq("stall_req_ready", req_ready, 0);
        check_eq("stall_cls_valid", cls_valid, 0);
      end
    end
    if (stall == 0) begin
      @(posedge clk); #1;
    end
    m_ptr = (w + 1) % N_REQ;
    if (ev) m_even++; else m_odd++;
    req_valid = '0;
    check_eq("done_resp_valid", resp_valid, 0);
    check_eq("done_busy", busy, 0);
    check_eq("even_cnt", even_cnt, exp_cnt(m_even));
    check_eq("odd_cnt", odd_cnt, exp_cnt(m_odd));
  endtask

  task automatic mid_reset(input logic [N_REQ-1:0] pat, input logic [8*N_REQ-1:0] data,
                           input int phase);
    @(negedge clk);
    req_valid  = pat;
    req_data   = data;
    resp_ready = 1'b1;
    @(posedge clk); #1;                       // ISSUE
    if (phase == 2) begin @(posedge clk); #1; end  // WAIT
    reset = 1'b0;
    #1;
    check_eq("mrst_cls_valid", cls_valid, 0);
    check_eq("mrst_cls_data", cls_data, 0);
    check_eq("mrst_resp_valid", resp_valid, 0);
    check_eq("mrst_resp_id", resp_id, 0);
    check_eq("mrst_resp_even", resp_even, 0);
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_req_ready", req_ready, 0);
    check_eq("mrst_cls_err", cls_err, 0);
    check_eq("mrst_even_cnt", even_cnt, 0);
    check_eq("mrst_odd_cnt", odd_cnt, 0);
    m_ptr = 0; m_err = 0; m_even = 0; m_odd = 0;
    repeat (2) @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check_eq("mrst_no_resp", resp_valid, 0);
    end
    run_txn(pat, data, 0);
  endtask

  initial begin
    int pulses0;
    logic [N_REQ-1:0] p;
    // ---- reset behaviour ----
    req_valid = 4'hF;
    #1;
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cls_valid", cls_valid, 0);
    #11;
    req_valid = '0;
    reset = 1'b1;
    pulses0 = cls_pulses;
    repeat (5) @(posedge clk);
    #1;
    check_eq("idle_resp_valid", resp_valid, 0);
    check_eq("idle_resp_id", resp_id, 0);
    check_eq("idle_resp_even", resp_even, 0);
    check_eq("idle_cls_data", cls_data, 0);
    check_eq("idle_busy0", busy, 0);
    check_eq("idle_cls_err", cls_err, 0);
    check_eq("idle_cnts", {even_cnt, odd_cnt}, 0);
    check_eq("idle_no_pulse", cls_pulses - pulses0, 0);

    // ---- single requester ----
    run_txn(4'b0001, 32'h0000_00FF, 0);
    run_txn(4'b0001, 32'h0000_0080, 0);

    // ---- rotation: bytes 0,1,2,3 ----
    m_ptr = m_ptr; // rotation expectations derive from model pointer
    for (int t = 0; t < 5; t++) run_txn(4'hF, 32'h0302_0100, 0);

    // ---- backpressure ----
    pulses0 = cls_pulses;
    run_txn(4'b0110, 32'h1122_3344, 6);
    check_eq("bp_pulse_count", cls_pulses - pulses0, 1);

    // ---- randomized traffic ----
    for (int t = 0; t < 60; t++) begin
      p = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      run_txn(p, $urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    end

    // ---- mid-operation reset ----
    mid_reset(4'b1100, 32'h0501_0203, 2);
    mid_reset(4'b0010, 32'h0000_4500, 1);

    // ---- statistics: 254 even and 3 odd bytes ----
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_ptr = 0; m_err = 0; m_even = 0; m_odd = 0;
    for (int t = 0; t < 257; t++) begin
      logic [7:0] b;
      b = 8'($urandom) & 8'hFE;
      if (t % 100 == 50) b = b | 8'h01;
      run_txn(4'b1000, {b, 24'h0}, 0);
    end
`ifdef PARITY_ARB_STATS_EN
    check_eq("stats_even_254", even_cnt, 254);
    check_eq("stats_odd_3", odd_cnt, 3);
`else
    check_eq("stats_even_off", even_cnt, 0);
    check_eq("stats_odd_off", odd_cnt, 0);
`endif

    // ---- malformed classifier result ----
    force_bad = 1'b1;
    run_txn(4'b0001, 32'h0000_0007, 0);
    force_bad = 1'b0;
    check_eq("err_sticky", cls_err, 1);
    run_txn(4'b0100, 32'h0010_0000, 0);
    check_eq("err_still_sticky", cls_err, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
